// File: rtl/noc_params.sv
// Shared router definitions: port sizing, flit format and input-buffer FSM states.
package noc_params;

  localparam int PORT_NUM            = 5;
  localparam int PORT_SIZE           = $clog2(PORT_NUM);
  localparam int PAYLOAD_W           = 16;
  localparam int BUFFER_SIZE_DEFAULT = 8;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    flit_label_t           flit_label;
    logic [PORT_SIZE-1:0]  dest;
    logic [PAYLOAD_W-1:0]  payload;
  } flit_t;

  typedef enum logic {IDLE, ACTIVE} ib_state_t;

  // BODY/TAIL can only legally appear after a HEAD has opened a packet.
  function automatic logic is_continuation(flit_label_t lbl);
    return (lbl == BODY) || (lbl == TAIL);
  endfunction

endpackage

// File: rtl/input_buffer_onoff_if.sv
// Link bundle of one router input port: upstream flit link plus switch-allocator side.
interface input_buffer_onoff_if;
  import noc_params::*;

  flit_t                data_i;
  logic                 valid_flit_i;
  logic                 on_off_o;
  flit_t                flit_o;
  logic                 switch_request_o;
  logic [PORT_SIZE-1:0] out_port_o;
  logic                 valid_sel_i;

  modport slave (
    input  data_i, valid_flit_i, valid_sel_i,
    output on_off_o, flit_o, switch_request_o, out_port_o
  );

  modport master (
    output data_i, valid_flit_i, valid_sel_i,
    input  on_off_o, flit_o, switch_request_o, out_port_o
  );
endinterface

// File: rtl/circular_buffer.sv
// Generic FIFO with registered write and combinational head read; push accepted
// when full only if a pop happens in the same cycle.
module circular_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count_next
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok, pop_ok;

  assign full       = (count_reg == (AW+1)'(DEPTH));
  assign empty      = (count_reg == '0);
  assign pop_ok     = pop && !empty;
  assign push_ok    = push && (!full || pop_ok);
  assign count_next = count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  assign rdata      = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end
endmodule

// File: rtl/input_buffer_onoff.sv
// Router input port: flit FIFO, packet-tracking FSM and on/off flow control.
// Define ONOFF_HYSTERESIS_EN for two-threshold hysteresis on on_off_o.
module input_buffer_onoff
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = BUFFER_SIZE_DEFAULT,
  parameter int OFF_THRESH  = 6,
  parameter int ON_THRESH   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input_buffer_onoff_if.slave  link,
  output logic                 overflow_o,
  output logic                 proto_err_o
);
  localparam int CW = $clog2(BUFFER_SIZE) + 1;
  localparam logic [CW-1:0] OFF_CNT = CW'(OFF_THRESH);

  if (OFF_THRESH > BUFFER_SIZE - 2 || ON_THRESH >= OFF_THRESH || BUFFER_SIZE < 4)
  begin : g_bad_thresholds
    $error("input_buffer_onoff: inconsistent BUFFER_SIZE/OFF_THRESH/ON_THRESH");
  end

  logic [$bits(flit_t)-1:0] head_bits;
  flit_t                    head_flit;
  logic                     full, empty, pop_fire;
  logic [CW-1:0]            count_next;

  ib_state_t                state_reg;
  logic [PORT_SIZE-1:0]     port_reg;
  logic                     on_off_reg, overflow_reg, proto_err_reg;

  circular_buffer #(.WIDTH($bits(flit_t)), .DEPTH(BUFFER_SIZE)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (link.valid_flit_i),
    .wdata      (link.data_i),
    .pop        (link.valid_sel_i),
    .rdata      (head_bits),
    .full       (full),
    .empty      (empty),
    .count_next (count_next)
  );

  assign head_flit = flit_t'(head_bits);
  assign pop_fire  = link.valid_sel_i && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      port_reg      <= '0;
      on_off_reg    <= 1'b1;
      overflow_reg  <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      if (link.valid_flit_i && full && !link.valid_sel_i) overflow_reg <= 1'b1;
      if (state_reg == IDLE && !empty && is_continuation(head_flit.flit_label))
        proto_err_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (pop_fire && head_flit.flit_label == HEAD) begin
            port_reg  <= head_flit.dest;
            state_reg <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (pop_fire && head_flit.flit_label == TAIL) state_reg <= IDLE;
        end
      endcase

`ifdef ONOFF_HYSTERESIS_EN
      // Between the thresholds the previous decision is held.
      if (count_next >= OFF_CNT)           on_off_reg <= 1'b0;
      else if (count_next <= CW'(ON_THRESH)) on_off_reg <= 1'b1;
`else
      on_off_reg <= (count_next < OFF_CNT);
`endif
    end
  end

  // Requests follow the head flit directly so a pushed flit is requested next cycle.
  assign link.switch_request_o = !empty;
  assign link.out_port_o       = (state_reg == ACTIVE) ? port_reg :
                                 (empty ? '0 : head_flit.dest);
  assign link.flit_o           = head_flit;
  assign link.on_off_o         = on_off_reg;
  assign overflow_o            = overflow_reg;
  assign proto_err_o           = proto_err_reg;
endmodule

// File: tb/tb_input_buffer_onoff.sv
// Self-checking bench for input_buffer_onoff: directed table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_input_buffer_onoff;
  import noc_params::*;

  localparam int DEPTH = 8;
  localparam int OFF_T = 6;
  localparam int ON_T  = 3;
`ifdef ONOFF_HYSTERESIS_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic overflow_o, proto_err_o;

  input_buffer_onoff_if bus();

  input_buffer_onoff #(.BUFFER_SIZE(DEPTH), .OFF_THRESH(OFF_T), .ON_THRESH(ON_T)) dut (
    .clk         (clk),
    .rst         (rst),
    .link        (bus),
    .overflow_o  (overflow_o),
    .proto_err_o (proto_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: packet-level view of the port.
  flit_t                q[$];
  bit                   m_in_pkt;
  logic [PORT_SIZE-1:0] m_port;
  bit                   m_on, m_ovf, m_perr;

  typedef struct {
    bit                   push;
    flit_label_t          lbl;
    logic [PORT_SIZE-1:0] dest;
    bit                   grant;
    bit                   exp_req;
    logic [PORT_SIZE-1:0] exp_port;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic flit_t mk(input flit_label_t l, input logic [PORT_SIZE-1:0] d,
                               input logic [PAYLOAD_W-1:0] p);
    flit_t f;
    f.flit_label = l;
    f.dest       = d;
    f.payload    = p;
    return f;
  endfunction

  task automatic model_reset();
    q.delete();
    m_in_pkt = 0;
    m_port   = '0;
    m_on     = 1;
    m_ovf    = 0;
    m_perr   = 0;
  endtask

  task automatic compare_model();
    logic [PORT_SIZE-1:0] exp_port;
    exp_port = m_in_pkt ? m_port : (q.size() != 0 ? q[0].dest : '0);
    chk("switch_request", bus.switch_request_o, (q.size() != 0));
    chk("out_port", bus.out_port_o, exp_port);
    chk("on_off", bus.on_off_o, m_on);
    chk("overflow", overflow_o, m_ovf);
    chk("proto_err", proto_err_o, m_perr);
    if (q.size() != 0) chk("flit_o", bus.flit_o, q[0]);
  endtask

  task automatic model_update(input bit push, input flit_t f, input bit grant);
    int    n;
    flit_t h;
    n = q.size();
    if (!m_in_pkt && n != 0 && (q[0].flit_label == BODY || q[0].flit_label == TAIL))
      m_perr = 1;
    if (grant && n != 0) begin
      h = q.pop_front();
      if (!m_in_pkt && h.flit_label == HEAD) begin
        m_in_pkt = 1;
        m_port   = h.dest;
      end else if (m_in_pkt && h.flit_label == TAIL) begin
        m_in_pkt = 0;
      end
    end
    if (push) begin
      if (n < DEPTH || (grant && n != 0)) q.push_back(f);
      else m_ovf = 1;
    end
    if (HYST) begin
      if (q.size() >= OFF_T)     m_on = 0;
      else if (q.size() <= ON_T) m_on = 1;
    end else begin
      m_on = (q.size() < OFF_T);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input bit push, input flit_t f, input bit grant);
    bus.valid_flit_i = push;
    bus.data_i       = f;
    bus.valid_sel_i  = grant;
    #1;
    compare_model();
    $display("cyc %0d push=%b lbl=%0d dest=%0d grant=%b req=%b port=%0d on=%b ovf=%b perr=%b",
             cyc, push, f.flit_label, f.dest, grant, bus.switch_request_o,
             bus.out_port_o, bus.on_off_o, overflow_o, proto_err_o);
    @(posedge clk);
    model_update(push, f, grant);
    cyc++;
    #1;
    bus.valid_flit_i = 1'b0;
    bus.valid_sel_i  = 1'b0;
  endtask

  initial begin
    flit_t nf;
    nf = mk(HEADTAIL, '0, '0);
    bus.data_i       = nf;
    bus.valid_flit_i = 1'b0;
    bus.valid_sel_i  = 1'b0;
    model_reset();

    tbl[0] = '{1, HEADTAIL, 3'd2, 0, 0, 3'd0};
    tbl[1] = '{0, HEADTAIL, 3'd0, 1, 1, 3'd2};
    tbl[2] = '{1, HEAD,     3'd3, 0, 0, 3'd0};
    tbl[3] = '{1, BODY,     3'd0, 0, 1, 3'd3};
    tbl[4] = '{1, BODY,     3'd1, 1, 1, 3'd3};
    tbl[5] = '{1, TAIL,     3'd4, 1, 1, 3'd3};
    tbl[6] = '{0, HEAD,     3'd0, 1, 1, 3'd3};
    tbl[7] = '{0, HEAD,     3'd0, 1, 1, 3'd3};
    tbl[8] = '{0, HEAD,     3'd0, 0, 0, 3'd0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset_request", bus.switch_request_o, 0);
    chk("reset_on_off", bus.on_off_o, 1);
    chk("reset_out_port", bus.out_port_o, 0);
    compare_model();

    // Directed single-flit and four-flit packets
    for (int i = 0; i < 9; i++) begin
      chk("tbl_request", bus.switch_request_o, tbl[i].exp_req);
      chk("tbl_out_port", bus.out_port_o, tbl[i].exp_port);
      step(tbl[i].push, mk(tbl[i].lbl, tbl[i].dest, 16'(100 + i)), tbl[i].grant);
    end

    // On/off thresholds
    for (int i = 0; i < 6; i++) begin
      step(1, mk(HEADTAIL, 3'd1, 16'(200 + i)), 0);
      chk("on_off_fill", bus.on_off_o, (i < 5));
    end
    for (int i = 0; i < 3; i++) begin
      step(0, nf, 1);
      chk("on_off_drain", bus.on_off_o, (i == 2) ? 1'b1 : !HYST);
    end

    // Fill to full, simultaneous push+pop at full, then a dropped push
    for (int i = 0; i < 5; i++) step(1, mk(HEADTAIL, 3'd2, 16'(300 + i)), 0);
    step(1, mk(HEADTAIL, 3'd3, 16'h0400), 1);
    chk("no_overflow_push_pop_full", overflow_o, 0);
    step(1, mk(HEADTAIL, 3'd4, 16'hdead), 0);
    chk("overflow_drop", overflow_o, 1);
    for (int i = 0; i < 9; i++) step(0, nf, 1);

    // Protocol error: BODY at head while idle
    step(1, mk(BODY, 3'd4, 16'h0500), 0);
    step(0, nf, 0);
    chk("proto_err_set", proto_err_o, 1);
    step(0, nf, 1);

    // Asynchronous reset mid-packet
    step(1, mk(HEAD, 3'd2, 16'h0600), 0);
    for (int i = 0; i < 3; i++) step(1, mk(BODY, 3'd0, 16'(16'h0601 + i)), 0);
    step(0, nf, 1);
    chk("active_port", bus.out_port_o, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_request", bus.switch_request_o, 0);
    chk("async_rst_port", bus.out_port_o, 0);
    chk("async_rst_on_off", bus.on_off_o, 1);
    chk("async_rst_overflow", overflow_o, 0);
    chk("async_rst_proto", proto_err_o, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("post_rst_empty", bus.switch_request_o, 0);
    step(1, mk(HEADTAIL, 3'd1, 16'h0700), 0);
    chk("post_rst_idle_port", bus.out_port_o, 1);
    step(0, nf, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      flit_t rf;
      bit    p, g;
      rf = mk(flit_label_t'($urandom_range(3, 0)), 3'($urandom_range(PORT_NUM - 1, 0)),
              16'($urandom));
      p = ($urandom_range(99, 0) < 55);
      g = ($urandom_range(99, 0) < 50);
      step(p, rf, g);
    end
    compare_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
